fifo_drain: RTL and testbench

//  Read-side controller for the pointer-based fifo: drives fifo_pop from fifo_empty
//  and captures the fall-through fifo_data into a 2-entry skid buffer.
//  Re-presents the data as a valid/ready stream, marking out_last every BURST beats.

---
 rtl/fifo_drain_if.sv | 20 ++
 rtl/fifo_drain.sv | 78 +++++++
 tb/tb_fifo_drain.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_if.sv
// Read-side handshake bundle between a fifo, the fifo_drain controller and its consumer.
interface fifo_drain_if #(parameter int WIDTH = 8);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_pop, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_pop, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_drain.sv
// Pops a fall-through fifo into a 2-entry skid buffer and re-presents it as a valid/ready
// stream with out_last every BURST beats. Optional pop statistics: FIFO_DRAIN_STATS_EN.
module fifo_drain #(
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    fifo_drain_if.master    bus
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [CNTW-1:0] pop_count
`endif
);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    if (BURST < 1 || CNTW < 1 || WIDTH < 1) begin : g_bad_cfg
        $error("fifo_drain: BURST, CNTW and WIDTH must all be >= 1");
    end

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

    occ_t             occ, occ_nxt;
    logic             pop, vld, acc, wr_hi;
    logic [WIDTH-1:0] d0, d1;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) occ <= EMPTY;
        else     occ <= occ_nxt;
    end

    // pop depends only on occupancy and fifo_empty, never on out_ready
    always_comb begin
        pop     = !rst && !bus.fifo_empty && (occ != TWO);
        vld     = !rst && (occ != EMPTY);
        acc     = vld && bus.out_ready;
        wr_hi   = (occ == ONE) && !acc;
        occ_nxt = occ;
        case (occ)
            EMPTY:   if (pop) occ_nxt = ONE;
            ONE: begin
                if (pop && !acc)      occ_nxt = TWO;
                else if (!pop && acc) occ_nxt = EMPTY;
            end
            TWO:     if (acc) occ_nxt = ONE;
            default: occ_nxt = EMPTY;
        endcase
    end

    // Shift on accept first, then the popped word lands in the first free slot
    always_ff @(posedge clk) begin
        if (acc) d0 <= d1;
        if (pop) begin
            if (wr_hi) d1 <= bus.fifo_data;
            else       d0 <= bus.fifo_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (acc) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

`ifdef FIFO_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)      pop_count <= '0;
        else if (pop) pop_count <= pop_count + 1'b1;
    end
`endif

    assign bus.fifo_pop  = pop;
    assign bus.out_valid = vld;
    assign bus.out_data  = d0;
    assign bus.out_last  = vld && (cnt == LAST);
endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: behavioural fall-through fifo in front, hand-computed checks.
module tb_fifo_drain;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_drain_if #(.WIDTH(W)) bus();

    logic [W-1:0] mem [0:63];
    logic [5:0]   rd = '0;
    logic [5:0]   wr = '0;

    assign bus.fifo_empty = (rd == wr);
    assign bus.fifo_data  = mem[rd];
    always @(posedge clk) if (bus.fifo_pop) rd <= rd + 1'b1;

`ifdef FIFO_DRAIN_STATS_EN
    logic [3:0] pop_count;
`endif

    fifo_drain #(.WIDTH(W), .BURST(4), .CNTW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .pop_count (pop_count)
`endif
    );

    int errs = 0;
    int nchk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr] = base + W'(i);
            wr      = wr + 1'b1;
        end
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_pop",   bus.fifo_pop,  0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last",  bus.out_last,  0);
        rst = 1'b0;

        // 1: idle with empty fifo
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_pop",   bus.fifo_pop,  0);
            chk("idle_valid", bus.out_valid, 0);
        end

        // 2: full-rate stream A0..A7, out_last on A3 and A7
        bus.out_ready = 1'b1;
        load(8'hA0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("s2_pop", bus.fifo_pop, 1);
            tick();
            chk("s2_valid", bus.out_valid, 1);
            chk("s2_data",  bus.out_data,  32'hA0 + i);
            chk("s2_last",  bus.out_last,  (i % 4 == 3) ? 1 : 0);
        end
        chk("s2_pop_end", bus.fifo_pop, 0);
        tick();
        chk("s2_drained", bus.out_valid, 0);

        // 3: stalled consumer fills the skid buffer, then drains with no gap
        bus.out_ready = 1'b0;
        load(8'hB0, 5);
        chk("s3_pop0", bus.fifo_pop, 1);
        tick();
        chk("s3_pop1",  bus.fifo_pop,  1);
        chk("s3_data1", bus.out_data,  32'hB0);
        tick();
        chk("s3_pop_two", bus.fifo_pop, 0);
        tick();
        tick();
        chk("s3_hold_pop",   bus.fifo_pop,  0);
        chk("s3_hold_valid", bus.out_valid, 1);
        chk("s3_hold_data",  bus.out_data,  32'hB0);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("s3_valid", bus.out_valid, 1);
            chk("s3_data",  bus.out_data,  32'hB0 + j);
            chk("s3_last",  bus.out_last,  (j == 3) ? 1 : 0);
            tick();
        end
        chk("s3_drained", bus.out_valid, 0);

        // 4: toggling ready, data must hold across each stall
        load(8'hC0, 8);
        tick();
        for (int k = 1; k <= 8; k++) begin
            chk("s4_valid", bus.out_valid, 1);
            chk("s4_data",  bus.out_data,  32'hC0 + (k - 1) / 2);
            bus.out_ready = (k % 2 == 0);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("s4_tail", bus.out_data, 32'hC4 + j);
            tick();
        end
        chk("s4_drained", bus.out_valid, 0);

        // 5: reset at occ=TWO mid-burst discards buffer and burst position
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load(8'hD0, 8);
        tick();
        chk("s5_d0", bus.out_data, 32'hD0);
        tick();
        chk("s5_d1", bus.out_data, 32'hD1);
        tick();
        bus.out_ready = 1'b0;
        tick();
        chk("s5_two_valid", bus.out_valid, 1);
        chk("s5_two_pop",   bus.fifo_pop,  0);
        chk("s5_two_data",  bus.out_data,  32'hD2);
        rst = 1'b1;
        #1;
        chk("s5_inrst_pop",   bus.fifo_pop,  0);
        chk("s5_inrst_valid", bus.out_valid, 0);
        chk("s5_inrst_last",  bus.out_last,  0);
        tick();
        rst = 1'b0;
        #1;
        chk("s5_post_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        tick();
        for (int j = 0; j < 4; j++) begin
            chk("s5_data", bus.out_data, 32'hD4 + j);
            chk("s5_last", bus.out_last, (j == 3) ? 1 : 0);
            tick();
        end
        chk("s5_drained", bus.out_valid, 0);

`ifdef FIFO_DRAIN_STATS_EN
        // 6: 4-bit pop counter wraps, 18 pops -> 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("s6_cnt_clr", pop_count, 0);
        load(8'h10, 18);
        for (int i = 0; i < 25; i++) tick();
        chk("s6_cnt_wrap", pop_count, 2);
        rst = 1'b1;
        tick();
        chk("s6_cnt_rst", pop_count, 0);
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
